// File: rtl/lod_pkg.sv
// Shared constants and helpers for the leading-one / run-length detector pipeline.
package lod_pkg;

    localparam logic MODE_LOD = 1'b0;
    localparam logic MODE_RUN = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/lod_group.sv
// Combinational leading-one detector for one G-bit slice; count is the number
// of zeros above the first 1 and is only meaningful when found is set.
module lod_group
    import lod_pkg::*;
#(
    parameter int G = 8
) (
    input  logic [G-1:0]          bits,
    output logic [clog2(G)-1:0]   count,
    output logic                  found
);

    localparam int LG = clog2(G);

    // Scan from the LSB upward so the highest set bit wins the last assignment.
    always_comb begin
        count = '0;
        found = |bits;
        for (int i = 0; i < G; i++) begin
            if (bits[i]) count = LG'(G - 1 - i);
        end
    end

endmodule

// File: rtl/lod_pipe.sv
// Two-stage leading-one / run-length detector with valid-ready handshakes.
// Stage 1 holds per-group results, stage 2 merges them into the final count.
module lod_pipe
    import lod_pkg::*;
#(
    parameter  int N  = 64,
    parameter  int G  = 8,
    parameter  int TW = 4,
    localparam int S  = clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in,
    input  logic          mode,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [S-1:0]  out,
    output logic          vld,
    output logic          run_bit,
    output logic [TW-1:0] out_tag
);

    localparam int NG = (N + G - 1) / G;
    localparam int NP = NG * G;
    localparam int LG = clog2(G);

    logic [N-1:0]   word;
    logic [NP-1:0]  padded;
    logic [NG-1:0]  grp_found;
    logic [LG-1:0]  grp_count [NG];

    logic           s1_valid;
    logic           s1_ready;
    logic [NG-1:0]  s1_found;
    logic [LG-1:0]  s1_count [NG];
    logic           s1_mode;
    logic           s1_run;
    logic [TW-1:0]  s1_tag;

    logic           s2_valid;
    logic [S-1:0]   s2_out_next;
    logic           s2_vld_next;

    assign s1_ready  = !s2_valid | out_ready;
    assign in_ready  = !s1_valid | s1_ready;
    assign out_valid = s2_valid;

    // Run-length mode turns the run into leading zeros; the shift drops the
    // always-zero MSB and is undone by the +1 in stage 2. Padding goes at the LSB.
    always_comb begin
        word = in;
        if (mode == MODE_RUN) word = (in ^ {N{in[N-1]}}) << 1;
        padded = '0;
        padded[NP-1 -: N] = word;
    end

    for (genvar g = 0; g < NG; g++) begin : g_group
        lod_group #(.G(G)) u_group (
            .bits  (padded[NP-1-g*G -: G]),
            .count (grp_count[g]),
            .found (grp_found[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_found <= '0;
            s1_mode  <= MODE_LOD;
            s1_run   <= 1'b0;
            s1_tag   <= '0;
            for (int g = 0; g < NG; g++) s1_count[g] <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_found <= grp_found;
                s1_mode  <= mode;
                s1_run   <= in[N-1];
                s1_tag   <= in_tag;
                for (int g = 0; g < NG; g++) s1_count[g] <= grp_count[g];
            end
        end
    end

    // Group 0 is the most significant; descending scan leaves the first found group.
    always_comb begin
        int  res;
        logic any;
        res = N;
        any = 1'b0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (s1_found[g]) begin
                any = 1'b1;
                res = g * G + int'(s1_count[g]);
            end
        end
        if (any && s1_mode == MODE_RUN) res = res + 1;
        if (res > N) res = N;
        s2_out_next = S'(res);
        s2_vld_next = any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            vld      <= 1'b0;
            run_bit  <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (s1_ready) s2_valid <= s1_valid;
            if (s1_valid && s1_ready) begin
                out     <= s2_out_next;
                vld     <= s2_vld_next;
                run_bit <= s1_run;
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_lod_pipe.sv
// Self-checking bench for lod_pipe: vector table, random streams, stalls and
// reset flush on an N=16 instance, plus a small N=12/G=4 instance.
module tb_lod_pipe;

    localparam int N  = 16;
    localparam int G  = 8;
    localparam int TW = 4;
    localparam int S  = 5;

    typedef struct packed {
        logic [S-1:0]  out;
        logic          vld;
        logic          run_bit;
        logic [TW-1:0] tag;
    } result_t;

    typedef struct packed {
        logic [N-1:0] word;
        logic         mode;
        logic [S-1:0] exp_out;
        logic         exp_vld;
        logic         exp_run;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_word;
    logic          mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [S-1:0]  out;
    logic          vld;
    logic          run_bit;
    logic [TW-1:0] out_tag;

    logic          in_valid_b;
    logic          in_ready_b;
    logic [11:0]   in_word_b;
    logic          mode_b;
    logic [3:0]    in_tag_b;
    logic          out_valid_b;
    logic [3:0]    out_b;
    logic          vld_b;
    logic          run_bit_b;
    logic [3:0]    out_tag_b;

    int      checks = 0;
    int      failures = 0;
    int      pops = 0;
    int      cycle = 0;
    result_t expq[$];
    result_t pending;
    result_t popped;
    result_t held_val;
    logic    held = 1'b0;
    vec_t    vectors [14];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    lod_pipe #(.N(N), .G(G), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_word),
        .mode      (mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .vld       (vld),
        .run_bit   (run_bit),
        .out_tag   (out_tag)
    );

    lod_pipe #(.N(12), .G(4), .TW(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in        (in_word_b),
        .mode      (mode_b),
        .in_tag    (in_tag_b),
        .out_valid (out_valid_b),
        .out_ready (1'b1),
        .out       (out_b),
        .vld       (vld_b),
        .run_bit   (run_bit_b),
        .out_tag   (out_tag_b)
    );

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count bits from the MSB that match the reference bit.
    function automatic result_t model(input logic [N-1:0] w, input logic m, input logic [TW-1:0] t);
        result_t r;
        int      cnt;
        logic    done;
        logic    ref_bit;
        ref_bit = m ? w[N-1] : 1'b0;
        cnt  = 0;
        done = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!done) begin
                if (w[i] == ref_bit) cnt++;
                else done = 1'b1;
            end
        end
        r.out     = S'(cnt);
        r.vld     = done;
        r.run_bit = w[N-1];
        r.tag     = t;
        return r;
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer, watch stalls.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) check_output("stall_hold", int'({out, vld, run_bit, out_tag}), int'(held_val));
            if (out_ready) begin
                held = 1'b0;
                pops++;
                if (expq.size() == 0) begin
                    check_output("unexpected_output", 1, 0);
                end else begin
                    popped = expq.pop_front();
                    check_output("out", int'(out), int'(popped.out));
                    check_output("vld", int'(vld), int'(popped.vld));
                    check_output("run_bit", int'(run_bit), int'(popped.run_bit));
                    check_output("out_tag", int'(out_tag), int'(popped.tag));
                end
            end else begin
                held = 1'b1;
                held_val = {out, vld, run_bit, out_tag};
            end
        end else begin
            held = 1'b0;
        end
        if (rst_n && in_valid && in_ready) expq.push_back(pending);
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic apply_stimulus(input logic [N-1:0] w, input logic m, input logic [TW-1:0] t,
                                  input result_t e);
        int waited;
        waited   = 0;
        in_word  = w;
        mode     = m;
        in_tag   = t;
        pending  = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_output("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited    = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_output("drain_left", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t    v;
        result_t e;
        int      c0;
        logic [N-1:0] w;
        logic    m;

        vectors[0]  = '{16'h0100, 1'b0, 5'd7,  1'b1, 1'b0};
        vectors[1]  = '{16'hF0FF, 1'b1, 5'd4,  1'b1, 1'b1};
        vectors[2]  = '{16'h0001, 1'b1, 5'd15, 1'b1, 1'b0};
        vectors[3]  = '{16'h0000, 1'b0, 5'd16, 1'b0, 1'b0};
        vectors[4]  = '{16'hFFFF, 1'b1, 5'd16, 1'b0, 1'b1};
        vectors[5]  = '{16'h8000, 1'b0, 5'd0,  1'b1, 1'b1};
        vectors[6]  = '{16'h0001, 1'b0, 5'd15, 1'b1, 1'b0};
        vectors[7]  = '{16'h7FFF, 1'b1, 5'd1,  1'b1, 1'b0};
        vectors[8]  = '{16'hFFFE, 1'b1, 5'd15, 1'b1, 1'b1};
        vectors[9]  = '{16'h0000, 1'b1, 5'd16, 1'b0, 1'b0};
        vectors[10] = '{16'h00FF, 1'b0, 5'd8,  1'b1, 1'b0};
        vectors[11] = '{16'h0080, 1'b0, 5'd8,  1'b1, 1'b0};
        vectors[12] = '{16'h8000, 1'b1, 5'd1,  1'b1, 1'b1};
        vectors[13] = '{16'hFFFF, 1'b0, 5'd0,  1'b1, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_word    = '0;
        mode       = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b0;
        in_valid_b = 1'b0;
        in_word_b  = '0;
        mode_b     = 1'b0;
        in_tag_b   = '0;
        pending    = '0;

        #12;
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out", int'(out), 0);
        check_output("reset_vld", int'(vld), 0);
        check_output("reset_run_bit", int'(run_bit), 0);
        check_output("reset_out_tag", int'(out_tag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_reset", int'(in_ready), 1);

        // Latency on an empty pipe.
        out_ready = 1'b1;
        apply_stimulus(16'h0100, 1'b0, 4'd1, '{5'd7, 1'b1, 1'b0, 4'd1});
        check_output("latency_edge1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check_output("latency_edge2", int'(out_valid), 1);
        wait_drain();

        for (int i = 0; i < 14; i++) begin
            v = vectors[i];
            e = '{v.exp_out, v.exp_vld, v.exp_run, TW'(i)};
            apply_stimulus(v.word, v.mode, TW'(i), e);
        end
        wait_drain();

        // Full-rate random stream.
        c0 = cycle;
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) w = ~w;
            m = 1'($urandom_range(0, 1));
            apply_stimulus(w, m, TW'(i), model(w, m, TW'(i)));
        end
        check_output("throughput_cycles", cycle - c0, 20);
        wait_drain();

        // Back-to-back stream with out_ready pattern 1,0,0,1.
        c0 = pops;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    w = 16'($urandom);
                    m = 1'($urandom_range(0, 1));
                    apply_stimulus(w, m, TW'(k), model(w, m, TW'(k)));
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        wait_drain();
        check_output("stall_stream_count", pops - c0, 8);

        // Reset with two words in flight.
        out_ready = 1'b0;
        apply_stimulus(16'h1234, 1'b0, 4'd9, model(16'h1234, 1'b0, 4'd9));
        apply_stimulus(16'hC000, 1'b1, 4'd10, model(16'hC000, 1'b1, 4'd10));
        check_output("pipe_full", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_clear", int'(out_valid), 0);
        check_output("async_out_tag", int'(out_tag), 0);
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("no_stale_output", int'(out_valid), 0);
        apply_stimulus(16'h0001, 1'b1, 4'd11, '{5'd15, 1'b1, 1'b0, 4'd11});
        wait_drain();

        // N=12, G=4 instance: {word, mode, expected out, expected vld}.
        begin
            logic [11:0] words_b [4];
            logic        modes_b [4];
            int          outs_b  [4];
            int          vlds_b  [4];
            words_b = '{12'h008, 12'h000, 12'hFF0, 12'h800};
            modes_b = '{1'b0, 1'b0, 1'b1, 1'b0};
            outs_b  = '{8, 12, 8, 0};
            vlds_b  = '{1, 0, 1, 1};
            for (int i = 0; i < 4; i++) begin
                in_word_b  = words_b[i];
                mode_b     = modes_b[i];
                in_tag_b   = 4'(i + 3);
                in_valid_b = 1'b1;
                @(posedge clk);
                #1;
                in_valid_b = 1'b0;
                @(posedge clk);
                #1;
                check_output("b_out_valid", int'(out_valid_b), 1);
                check_output("b_out", int'(out_b), outs_b[i]);
                check_output("b_vld", int'(vld_b), vlds_b[i]);
                check_output("b_out_tag", int'(out_tag_b), i + 3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
